// File: rtl/alu_bist.sv
// Built-in self test for a 32-bit ALU: drives LFSR-derived operands through a
// fixed op sequence, compacts results into a MISR and counts zero-flag errors.
module alu_bist #(
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = 32'h00000001,
  parameter logic [31:0] GOLDEN      = 32'h00000000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [3:0]  aluc_out,
  input  logic [31:0] s_in,
  input  logic        z_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic [7:0]  z_err_count
);

  localparam int unsigned W       = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(9);
  localparam logic [CNT_W-1:0] NUM_VEC   = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] ZERR_MAX  = CNT_W'(255);
  localparam logic [W-1:0]     SEED_EFF  = (SEED == '0) ? W'(32'h00000001) : SEED;
  localparam logic [W-1:0]     CRC_POLY  = W'(32'h04C11DB7);
  localparam logic [W-1:0]     LFSR_TAPS = W'(32'h80200003);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, FIN} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       lfsr_q, lfsr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   vcnt_q, vcnt_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [OP_W-1:0]    aluc_q, aluc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [W-1:0]       sig_q, sig_d;
  logic [CNT_W-1:0]   zerr_q, zerr_d;

  function automatic logic [OP_W-1:0] op_code(input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_W'(0): op_code = 4'b0000;
      IDX_W'(1): op_code = 4'b0100;
      IDX_W'(2): op_code = 4'b0001;
      IDX_W'(3): op_code = 4'b0101;
      IDX_W'(4): op_code = 4'b0010;
      IDX_W'(5): op_code = 4'b0110;
      IDX_W'(6): op_code = 4'b0011;
      IDX_W'(7): op_code = 4'b0111;
      IDX_W'(8): op_code = 4'b1111;
      IDX_W'(9): op_code = 4'b1011;
      default:   op_code = 4'b0000;
    endcase
  endfunction

  function automatic logic [W-1:0] half_swap(input logic [W-1:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
  endfunction

  function automatic logic [W-1:0] misr_next(input logic [W-1:0] sig,
                                             input logic [W-1:0] s,
                                             input logic         z);
    return ((sig << 1) ^ (sig[W-1] ? CRC_POLY : '0)) ^ s ^ {{(W-1){1'b0}}, z};
  endfunction

  // Operands for the next DRIVE are loaded on the edge that enters it, so they
  // are already stable during the DRIVE cycle and held through CAPTURE.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    vcnt_d  = vcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    aluc_d  = aluc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    sig_d   = sig_q;
    zerr_d  = zerr_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = DRIVE;
          lfsr_d  = SEED_EFF;
          sig_d   = '1;
          zerr_d  = '0;
          idx_d   = '0;
          vcnt_d  = '0;
          a_d     = SEED_EFF;
          b_d     = half_swap(SEED_EFF);
          aluc_d  = op_code('0);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        sig_d = misr_next(sig_q, s_in, z_in);
        if ((z_in != (s_in == '0)) && (zerr_q != ZERR_MAX)) begin
          zerr_d = zerr_q + CNT_W'(1);
        end
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + IDX_W'(1);
          aluc_d  = op_code(idx_q + IDX_W'(1));
          state_d = DRIVE;
        end else begin
          idx_d  = '0;
          vcnt_d = vcnt_q + CNT_W'(1);
          lfsr_d = lfsr_step(lfsr_q);
          if ((vcnt_q + CNT_W'(1)) == NUM_VEC) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (sig_d == GOLDEN) && (zerr_d == '0);
          end else begin
            state_d = DRIVE;
            a_d     = lfsr_step(lfsr_q);
            b_d     = half_swap(lfsr_step(lfsr_q));
            aluc_d  = op_code('0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      idx_q   <= '0;
      vcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      aluc_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
      zerr_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      vcnt_q  <= vcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aluc_q  <= aluc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
      zerr_q  <= zerr_d;
    end
  end

  assign a_out       = a_q;
  assign b_out       = b_q;
  assign aluc_out    = aluc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign signature   = sig_q;
  assign z_err_count = zerr_q;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: a reference ALU drives s_in/z_in, and a
// run-timeline model predicts every output on every cycle.
module tb_alu_bist;

  localparam int          NV   = 3;
  localparam logic [31:0] SEED = 32'h00000001;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  function automatic logic [31:0] swap16(input logic [31:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  function automatic logic [3:0] op_at(input int i);
    case (i)
      0: return 4'b0000;
      1: return 4'b0100;
      2: return 4'b0001;
      3: return 4'b0101;
      4: return 4'b0010;
      5: return 4'b0110;
      6: return 4'b0011;
      7: return 4'b0111;
      8: return 4'b1111;
      9: return 4'b1011;
      default: return 4'b0000;
    endcase
  endfunction

  // Reference ALU: add, sub, and, or, xor, lui, sll, srl, sra.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0100: return a - b;
      4'b0001: return a & b;
      4'b0101: return a | b;
      4'b0010: return a ^ b;
      4'b0110: return {b[15:0], 16'h0000};
      4'b0011, 4'b1011: return b << a[4:0];
      4'b0111: return b >> a[4:0];
      4'b1111: return 32'($signed(b) >>> a[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] sig, input logic [31:0] s,
                                       input logic z);
    return ((sig << 1) ^ (sig[31] ? POLY : 32'h0)) ^ s ^ {31'b0, z};
  endfunction

  function automatic logic [31:0] run_sig(input bit fault);
    logic [31:0] l, s, sig;
    logic z;
    l = SEED;
    sig = 32'hFFFFFFFF;
    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < 10; i++) begin
        s = alu_f(l, swap16(l), op_at(i));
        z = fault ? 1'b0 : (s == 32'h0);
        sig = misr(sig, s, z);
      end
      l = lfsr_next(l);
    end
    return sig;
  endfunction

  localparam logic [31:0] GOLD = run_sig(1'b0);

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        fault_mode = 1'b0;
  logic [31:0] a_out, b_out, s_in, signature;
  logic [3:0]  aluc_out;
  logic        z_in, busy, done, pass;
  logic [7:0]  z_err_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clock = ~clock;

  assign s_in = alu_f(a_out, b_out, aluc_out);
  assign z_in = fault_mode ? 1'b0 : (s_in == 32'h0);

  alu_bist #(.NUM_VECTORS(NV), .SEED(SEED), .GOLDEN(GOLD)) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .a_out(a_out), .b_out(b_out), .aluc_out(aluc_out),
    .s_in(s_in), .z_in(z_in),
    .busy(busy), .done(done), .pass(pass),
    .signature(signature), .z_err_count(z_err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected per-capture history of a whole run.
  logic [31:0] sig_hist  [0:10*NV];
  logic [7:0]  zerr_hist [0:10*NV];
  logic [31:0] lfsr_v    [0:NV-1];

  task automatic build_hist(input bit fault);
    logic [31:0] l, s;
    logic z;
    int c, ze;
    l = SEED; c = 0; ze = 0;
    sig_hist[0] = 32'hFFFFFFFF;
    zerr_hist[0] = 8'd0;
    for (int v = 0; v < NV; v++) begin
      lfsr_v[v] = l;
      for (int i = 0; i < 10; i++) begin
        s = alu_f(l, swap16(l), op_at(i));
        z = fault ? 1'b0 : (s == 32'h0);
        sig_hist[c+1] = misr(sig_hist[c], s, z);
        if ((z != (s == 32'h0)) && ze < 255) ze++;
        zerr_hist[c+1] = 8'(ze);
        c++;
      end
      l = lfsr_next(l);
    end
  endtask

  // Timeline model: phase 0 = idle after reset, 1 = running (cycle m_k), 2 = finished.
  int m_phase = 0;
  int m_k = 0;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_phase = 0;
      m_k = 0;
    end else if (m_phase != 1 && start) begin
      build_hist(fault_mode);
      m_phase = 1;
      m_k = 1;
    end else if (m_phase == 1) begin
      if (m_k == 20*NV) m_phase = 2;
      else m_k++;
    end
  end

  always @(negedge clock) begin : compare
    int v, i, c, last;
    if (chk_en) begin
      last = 10*NV;
      case (m_phase)
        0: begin
          chk("idle_a", a_out, 32'h0);
          chk("idle_b", b_out, 32'h0);
          chk("idle_aluc", 32'(aluc_out), 32'h0);
          chk("idle_busy", 32'(busy), 32'h0);
          chk("idle_done", 32'(done), 32'h0);
          chk("idle_pass", 32'(pass), 32'h0);
          chk("idle_sig", signature, 32'h0);
          chk("idle_zerr", 32'(z_err_count), 32'h0);
        end
        1: begin
          v = (m_k - 1) / 20;
          i = ((m_k - 1) % 20) / 2;
          c = (m_k - 1) / 2;
          chk("run_a", a_out, lfsr_v[v]);
          chk("run_b", b_out, swap16(lfsr_v[v]));
          chk("run_aluc", 32'(aluc_out), 32'(op_at(i)));
          chk("run_busy", 32'(busy), 32'h1);
          chk("run_done", 32'(done), 32'h0);
          chk("run_sig", signature, sig_hist[c]);
          chk("run_zerr", 32'(z_err_count), 32'(zerr_hist[c]));
        end
        default: begin
          chk("fin_a", a_out, lfsr_v[NV-1]);
          chk("fin_b", b_out, swap16(lfsr_v[NV-1]));
          chk("fin_aluc", 32'(aluc_out), 32'(4'b1011));
          chk("fin_busy", 32'(busy), 32'h0);
          chk("fin_done", 32'(done), 32'h1);
          chk("fin_pass", 32'(pass),
              32'((sig_hist[last] == GOLD) && (zerr_hist[last] == 8'd0)));
          chk("fin_sig", signature, sig_hist[last]);
          chk("fin_zerr", 32'(z_err_count), 32'(zerr_hist[last]));
        end
      endcase
    end
  end

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  // Returns the number of cycles from the first DRIVE cycle until done is seen.
  task automatic wait_done(input int already, output int len);
    int n;
    n = already;
    while (!done && n < 500) begin
      @(negedge clock);
      n++;
    end
    len = n - 1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int len;
    // Model pins against hand-computed values.
    chk("pin_lfsr1", lfsr_next(32'h00000001), 32'h80200003);
    chk("pin_lfsr2", lfsr_next(32'h80200003), 32'hC0300002);
    chk("pin_misr", misr(32'hFFFFFFFF, 32'h00010001, 1'b0), 32'hFB3FE248);
    chk("pin_alu_and", alu_f(32'h1, 32'h00010000, 4'b0001), 32'h0);
    build_hist(1'b1);
    chk("pin_fault_zerr", 32'(zerr_hist[10*NV]), 32'd4);

    repeat (3) @(negedge clock);
    resetn = 1'b1;
    chk_en = 1'b1;
    chk("reset_sig", signature, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clock);

    // Run 1: first-vector literals, ignored start mid-run, exact length.
    pulse_start();
    chk("first_a", a_out, 32'h00000001);
    chk("first_b", b_out, 32'h00010000);
    chk("first_aluc", 32'(aluc_out), 32'h0);
    @(negedge clock);
    @(negedge clock);
    chk("third_aluc", 32'(aluc_out), 32'(4'b0100));
    chk("third_sig", signature, 32'hFB3FE248);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    wait_done(5, len);
    chk("run1_len", 32'(len), 32'(20*NV));
    chk("run1_sig", signature, GOLD);
    chk("run1_zerr", 32'(z_err_count), 32'h0);
    chk("run1_pass", 32'(pass), 32'h1);
    repeat (3) @(negedge clock);

    // Run 2: restart from FIN, identical result.
    pulse_start();
    chk("restart_done", 32'(done), 32'h0);
    chk("restart_busy", 32'(busy), 32'h1);
    wait_done(1, len);
    chk("run2_len", 32'(len), 32'(20*NV));
    chk("run2_sig", signature, GOLD);
    chk("run2_pass", 32'(pass), 32'h1);

    // Run 3: zero flag stuck low.
    fault_mode = 1'b1;
    pulse_start();
    wait_done(1, len);
    chk("fault_zerr", 32'(z_err_count), 32'd4);
    chk("fault_pass", 32'(pass), 32'h0);
    @(negedge clock);
    fault_mode = 1'b0;

    // Run 4: asynchronous reset mid-run, then quiet idle.
    pulse_start();
    repeat (6) @(negedge clock);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("rst_a", a_out, 32'h0);
    chk("rst_b", b_out, 32'h0);
    chk("rst_aluc", 32'(aluc_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sig", signature, 32'h0);
    @(negedge clock); resetn = 1'b1;
    repeat (10) @(negedge clock);
    chk("post_rst_a", a_out, 32'h0);
    chk("post_rst_done", 32'(done), 32'h0);

    // Run 5: normal run after reset.
    pulse_start();
    wait_done(1, len);
    chk("run5_len", 32'(len), 32'(20*NV));
    chk("run5_sig", signature, GOLD);
    chk("run5_pass", 32'(pass), 32'h1);
    repeat (2) @(negedge clock);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter NUM_VECTORS, default 16, meaning: number of LFSR operand vectors per run (range 1..255).
REQ-002 Parameter SEED, default 32'h00000001, meaning: LFSR start value; a value of 0 SHALL be replaced by 32'h00000001.
REQ-003 Parameter GOLDEN, default 32'h00000000, meaning: expected final signature, fixed at build time from the team's ALU model.
REQ-004 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle run request.
REQ-007 a_out  output  32  operand a driven to the ALU.
REQ-008 b_out  output  32  operand b driven to the ALU.
REQ-009 aluc_out  output  4  ALU op code driven to the ALU.
REQ-010 s_in  input  32  ALU result.
REQ-011 z_in  input  1  ALU zero flag.
REQ-012 busy  output  1  high while a run is in progress.
REQ-013 done  output  1  high from run completion until the next accepted start.
REQ-014 pass  output  1  valid only while done is high.
REQ-015 signature  output  32  MISR contents.
REQ-016 z_err_count  output  8  count of zero-flag mismatches; saturates at 255.

Function
REQ-017 The FSM SHALL have four states: IDLE, DRIVE, CAPTURE, FIN.
REQ-018 In IDLE or FIN, start=1 SHALL load the following on the next edge, then enter DRIVE with busy=1 and done=0:
  - lfsr <= SEED
  - signature <= 32'hFFFFFFFF
  - z_err_count <= 0
  - op index <= 0
  - vector count <= 0
REQ-019 start SHALL be ignored while busy=1.
REQ-020 The op sequence per vector SHALL be indices 0..9 = 0000, 0100, 0001, 0101, 0010, 0110, 0011, 0111, 1111, 1011.
REQ-021 In DRIVE, the registered outputs SHALL be a_out=lfsr, b_out={lfsr[15:0],lfsr[31:16]}, aluc_out=op[index]; the next state SHALL be CAPTURE.
REQ-022 In CAPTURE, a_out, b_out and aluc_out SHALL be held, and s_in and z_in SHALL be sampled; the ALU settles combinationally within one cycle.
REQ-023 On each CAPTURE edge the signature SHALL update as signature <= ((signature<<1) ^ (signature[31] ? 32'h04C11DB7 : 0)) ^ s_in ^ {31'b0,z_in}.
REQ-024 On each CAPTURE edge, if z_in != (s_in==0), z_err_count SHALL increment, saturating at 255.
REQ-025 After CAPTURE with index<9, index SHALL increment and the FSM SHALL return to DRIVE.
REQ-026 After CAPTURE with index=9:
  - index SHALL wrap to 0 and the vector count SHALL increment.
  - lfsr SHALL advance one Galois step: lfsr <= (lfsr>>1) ^ (lfsr[0] ? 32'h80200003 : 0).
  - If the new vector count equals NUM_VECTORS, the next state SHALL be FIN; otherwise DRIVE.
REQ-027 A run SHALL last exactly 20*NUM_VECTORS cycles from the first DRIVE to FIN entry.
REQ-028 In FIN: busy=0, done=1, and pass=(signature==GOLDEN)&&(z_err_count==0).
REQ-029 In FIN, signature and z_err_count SHALL hold until the next accepted start.
REQ-030 In IDLE and FIN, a_out, b_out and aluc_out SHALL hold their last driven values.

Reset
REQ-031 resetn=0 SHALL immediately force the following, at any time including mid-run:
  - state IDLE
  - a_out=0, b_out=0, aluc_out=0
  - busy=0, done=0, pass=0
  - signature=0, z_err_count=0
  - lfsr=SEED, index=0, vector count=0
REQ-032 After resetn rises, the block SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-033 Reset check: assert resetn=0 mid-run (e.g. at cycle 7) -> all outputs 0 within the same cycle; after resetn=1 with start=0 for 10 cycles -> all outputs still 0.
REQ-034 First vector: start pulse with SEED=1 -> at the first DRIVE cycle a_out=32'h00000001, b_out=32'h00010000, aluc_out=4'b0000; at the third cycle aluc_out=4'b0100.
REQ-035 Full run: NUM_VECTORS=1 with the real ALU attached -> done=1 exactly 20 cycles after the first DRIVE; signature equals the reference-model value; z_err_count=0; pass=1 when GOLDEN is set to that value.
REQ-036 Fault injection: force z_in=0 on every cycle where s_in=0 (e.g. the 0100 op with a=b) -> z_err_count>0 and pass=0 at done.
REQ-037 Protocol check: start pulses while busy=1 are ignored (run length unchanged); start in FIN restarts the run with done=0 on the next cycle, and repeated runs produce identical signatures.
